// File: rtl/phase_lead.sv
// Predictive edge generator. Measures the half-period of the synchronised
// zero-crossing input and, once locked, toggles sgn_lead LEAD clocks ahead of
// the next expected input edge. While unlocked, sgn_lead is a registered
// pass-through of the synchronised input.
module phase_lead #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LEAD     = 50,
  parameter int unsigned MIN_HALF = 60,
  parameter int unsigned MAX_HALF = 255,
  parameter int unsigned TOL      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sgn,
  output logic             sgn_lead,
  output logic             locked,
  output logic [CNT_W-1:0] half_per
);

  typedef enum logic [1:0] {StIdle, StAcq, StLock} state_e;

  localparam logic [CNT_W-1:0] MinHalfC = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MaxHalfC = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] LeadC    = CNT_W'(LEAD);
  localparam logic [CNT_W:0]   TolC     = (CNT_W + 1)'(TOL);

  logic             sync1;
  logic             sgn_s;
  logic             sgn_d;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic             fired;
  logic             fired_d;
  logic             sgn_lead_d;
  logic [CNT_W-1:0] half_per_d;
  state_e           state_q;
  state_e           state_d;

  logic             p_in_range;
  logic             valid;
  logic             timeout;
  logic [CNT_W:0]   p_ext;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   diff;
  logic             within_tol;
  logic [CNT_W-1:0] lead_pt;
  logic             fire;

  // Two-FF synchroniser plus a delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sgn_s <= 1'b0;
      sgn_d <= 1'b0;
    end else begin
      sync1 <= sgn;
      sgn_s <= sync1;
      sgn_d <= sgn_s;
    end
  end

  assign edge_det = sgn_s ^ sgn_d;

  // Half-period counter: restarts at 1 after each edge, saturates at MAX_HALF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= CNT_W'(1);
    end else if (cnt != MaxHalfC) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The counter value seen in an edge cycle is the measured half-period.
  assign p_in_range = (cnt >= MinHalfC) && (cnt < MaxHalfC);
  assign valid      = edge_det && p_in_range;
  assign timeout    = (cnt == MaxHalfC);

  // Absolute difference in one extra bit so it never wraps.
  assign p_ext      = {1'b0, cnt};
  assign h_ext      = {1'b0, half_per};
  assign diff       = (p_ext >= h_ext) ? (p_ext - h_ext) : (h_ext - p_ext);
  assign within_tol = (diff <= TolC);

  // Next state and half-period update.
  always_comb begin
    state_d    = state_q;
    half_per_d = half_per;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          state_d    = StAcq;
          half_per_d = cnt;
        end
      end
      StAcq, StLock: begin
        if (edge_det) begin
          if (valid) begin
            half_per_d = cnt;
            state_d    = within_tol ? StLock : StAcq;
          end else begin
            state_d = StIdle;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // half_per >= MIN_HALF > LEAD whenever locked, so this never underflows in use.
  assign lead_pt = half_per - LeadC;

  // Predicted toggle only while staying in LOCK; a real edge always takes priority.
  assign fire = !edge_det && (state_q == StLock) && (state_d == StLock) && !fired &&
                (cnt == lead_pt);

  // Output next-state: real edge, predicted toggle, or pass-through when unlocked.
  always_comb begin
    sgn_lead_d = sgn_lead;
    fired_d    = fired;
    if (edge_det) begin
      sgn_lead_d = sgn_s;
      fired_d    = 1'b0;
    end else if (fire) begin
      sgn_lead_d = ~sgn_s;
      fired_d    = 1'b1;
    end else if ((state_q != StLock) || (state_d != StLock)) begin
      sgn_lead_d = sgn_s;
    end
  end

  // State, measured half-period and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      half_per <= '0;
      sgn_lead <= 1'b0;
      fired    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_per <= half_per_d;
      sgn_lead <= sgn_lead_d;
      fired    <= fired_d;
    end
  end

  assign locked = (state_q == StLock);

endmodule

// File: tb/tb_phase_lead.sv
// Directed bench for phase_lead: reset, acquisition, tracking, glitch,
// timeout, early edge and asynchronous reset while locked.
module tb_phase_lead;

  logic       clk;
  logic       rst_n;
  logic       sgn;
  logic       sgn_lead;
  logic       locked;
  logic [7:0] half_per;

  int checks;
  int failures;

  phase_lead #(
    .CNT_W   (8),
    .LEAD    (50),
    .MIN_HALF(60),
    .MAX_HALF(255),
    .TOL     (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sgn     (sgn),
    .sgn_lead(sgn_lead),
    .locked  (locked),
    .half_per(half_per)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset, then hold sgn low long enough for the counter to saturate.
  task automatic do_reset();
    rst_n = 1'b0;
    sgn   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(300);
  endtask

  // Three edges 100 clocks apart: first invalid (saturated), second ACQ, third LOCK.
  // Leaves sgn=1, 100 clocks into the first locked half-period.
  task automatic acquire_lock();
    do_reset();
    sgn = 1'b1; tick(100);
    sgn = 1'b0; tick(100);
    sgn = 1'b1; tick(100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sgn   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) sgn = ~sgn;
      tick(1);
      checks++;
      if (sgn_lead !== 1'b0 || locked !== 1'b0 || half_per !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got lead=%b lock=%b hp=%0d exp 0/0/0",
                 i, sgn_lead, locked, half_per);
      end
    end
    sgn   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    sgn = 1'b1;
    tick(2);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL reset_passthru_early got=%b exp=0", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL reset_passthru_3clk got=%b exp=1", sgn_lead);
    end
  endtask

  task automatic test_lock_acquire();
    do_reset();
    sgn = 1'b1; tick(100);
    sgn = 1'b0; tick(3);
    checks++;
    if (half_per !== 8'd100 || locked !== 1'b0) begin
      failures++;
      $display("FAIL acq_edge2 got hp=%0d lock=%b exp hp=100 lock=0", half_per, locked);
    end
    tick(97);
    sgn = 1'b1; tick(2);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL acq_edge3_early got=%b exp=0", sgn_lead);
    end
    tick(1);
    checks++;
    if (locked !== 1'b1 || sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL acq_edge3 got lock=%b lead=%b exp lock=1 lead=1", locked, sgn_lead);
    end
    tick(49);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL acq_pre_lead got=%b exp=1", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL acq_lead_toggle got=%b exp=0", sgn_lead);
    end
    tick(47);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL acq_lead_hold got=%b exp=0", sgn_lead);
    end
    sgn = 1'b0; tick(3);
    checks++;
    if (locked !== 1'b1 || half_per !== 8'd100 || sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL acq_edge4 got lock=%b hp=%0d lead=%b exp 1/100/0",
               locked, half_per, sgn_lead);
    end
    tick(49);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL acq_pre_lead2 got=%b exp=0", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL acq_lead_toggle2 got=%b exp=1", sgn_lead);
    end
    tick(47);
  endtask

  // Continues from test_lock_acquire: sgn=0, locked at 100.
  task automatic test_tracking();
    sgn = 1'b1; tick(3);
    checks++;
    if (locked !== 1'b1 || half_per !== 8'd100) begin
      failures++;
      $display("FAIL trk_a got lock=%b hp=%0d exp 1/100", locked, half_per);
    end
    tick(91);
    sgn = 1'b0; tick(3);
    checks++;
    if (locked !== 1'b1 || half_per !== 8'd94) begin
      failures++;
      $display("FAIL trk_94 got lock=%b hp=%0d exp 1/94", locked, half_per);
    end
    tick(43);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL trk_94_pre got=%b exp=0", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL trk_94_lead got=%b exp=1", sgn_lead);
    end
    tick(47);
    sgn = 1'b1; tick(3);
    checks++;
    if (locked !== 1'b1 || half_per !== 8'd94) begin
      failures++;
      $display("FAIL trk_94b got lock=%b hp=%0d exp 1/94", locked, half_per);
    end
    tick(117);
    sgn = 1'b0; tick(3);
    checks++;
    if (locked !== 1'b0 || half_per !== 8'd120 || sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL trk_120_unlock got lock=%b hp=%0d lead=%b exp 0/120/0",
               locked, half_per, sgn_lead);
    end
    tick(70);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL trk_acq_no_lead got=%b exp=0", sgn_lead);
    end
    tick(47);
    sgn = 1'b1; tick(3);
    checks++;
    if (locked !== 1'b1 || half_per !== 8'd120) begin
      failures++;
      $display("FAIL trk_relock got lock=%b hp=%0d exp 1/120", locked, half_per);
    end
    tick(69);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL trk_120_pre got=%b exp=1", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL trk_120_lead got=%b exp=0", sgn_lead);
    end
    tick(47);
  endtask

  task automatic test_glitch();
    acquire_lock();
    sgn = 1'b0; tick(30);
    sgn = 1'b1; tick(2);
    checks++;
    if (locked !== 1'b1 || sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL glitch_pre got lock=%b lead=%b exp 1/0", locked, sgn_lead);
    end
    tick(1);
    checks++;
    if (locked !== 1'b0 || sgn_lead !== 1'b1 || half_per !== 8'd100) begin
      failures++;
      $display("FAIL glitch_edge got lock=%b lead=%b hp=%0d exp 0/1/100",
               locked, sgn_lead, half_per);
    end
    tick(17);
    sgn = 1'b0; tick(2);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL glitch_end_early got=%b exp=1", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL glitch_end got lead=%b lock=%b exp 0/0", sgn_lead, locked);
    end
    tick(97);
    sgn = 1'b1; tick(3);
    checks++;
    if (locked !== 1'b0 || half_per !== 8'd100 || sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL glitch_acq got lock=%b hp=%0d lead=%b exp 0/100/1",
               locked, half_per, sgn_lead);
    end
    tick(97);
    sgn = 1'b0; tick(3);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL glitch_relock got=%b exp=1", locked);
    end
    tick(49);
    checks++;
    if (sgn_lead !== 1'b0) begin
      failures++;
      $display("FAIL glitch_relock_pre got=%b exp=0", sgn_lead);
    end
    tick(1);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL glitch_relock_lead got=%b exp=1", sgn_lead);
    end
  endtask

  task automatic test_timeout();
    acquire_lock();
    sgn = 1'b0; tick(250);
    checks++;
    if (locked !== 1'b1 || sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL timeout_before got lock=%b lead=%b exp 1/1", locked, sgn_lead);
    end
    tick(8);
    checks++;
    if (locked !== 1'b0 || sgn_lead !== 1'b0 || half_per !== 8'd100) begin
      failures++;
      $display("FAIL timeout_after got lock=%b lead=%b hp=%0d exp 0/0/100",
               locked, sgn_lead, half_per);
    end
  endtask

  task automatic test_early_edge();
    acquire_lock();
    sgn = 1'b0; tick(40);
    checks++;
    if (sgn_lead !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL early_before got lead=%b lock=%b exp 0/1", sgn_lead, locked);
    end
    sgn = 1'b1; tick(3);
    checks++;
    if (locked !== 1'b0 || sgn_lead !== 1'b1 || half_per !== 8'd100) begin
      failures++;
      $display("FAIL early_edge got lock=%b lead=%b hp=%0d exp 0/1/100",
               locked, sgn_lead, half_per);
    end
    tick(60);
    checks++;
    if (sgn_lead !== 1'b1) begin
      failures++;
      $display("FAIL early_no_extra got=%b exp=1", sgn_lead);
    end
  endtask

  task automatic test_reset_mid();
    acquire_lock();
    sgn = 1'b0; tick(60);
    checks++;
    if (sgn_lead !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_before got lead=%b lock=%b exp 1/1", sgn_lead, locked);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sgn_lead !== 1'b0 || locked !== 1'b0 || half_per !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_async got lead=%b lock=%b hp=%0d exp 0/0/0",
               sgn_lead, locked, half_per);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sgn      = 1'b0;
    tick(1);
    test_reset();
    test_lock_acquire();
    test_tracking();
    test_glitch();
    test_timeout();
    test_early_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_lead.md
Name: phase_lead

Overview:
- Predictive edge generator for the feedback path: measures the half-period of the incoming zero-crossing signal `sgn`.
- Once locked, it emits `sgn_lead`, which toggles LEAD clocks before the next expected `sgn` edge.
- It is the advance-direction counterpart of the team's edge-delay block. It drives the gate timing when loop delay must be compensated.
- While unlocked, `sgn_lead` is a registered pass-through of the synchronised input.

Parameters:
- CNT_W, 8: width of the period counter and of `half_per`.
- LEAD, 50: advance in clocks; must satisfy 1 <= LEAD < MIN_HALF.
- MIN_HALF, 60: shortest accepted half-period in clocks.
- MAX_HALF, 255: counter saturation / timeout value; must be <= 2^CNT_W-1.
- TOL, 8: maximum allowed change between consecutive half-periods while locked.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- sgn, input, 1: raw feedback polarity, asynchronous to clk.
- sgn_lead, output, 1: advanced (or pass-through) polarity, registered.
- locked, output, 1: high while the prediction is active.
- half_per, output, CNT_W: last accepted half-period in clocks.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - sync FFs, sgn_d, sgn_lead, locked, fired = 0.
  - half_per = 0; cnt = 0; state = IDLE.
- Input conditioning and edge detect:
  - Two-FF synchroniser gives `sgn_s`; one more FF gives `sgn_d`.
  - edge = sgn_s ^ sgn_d.
- Counter:
  - On an edge cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at MAX_HALF.
  - The cnt value sampled in an edge cycle is the measured half-period P.
- valid = edge && (MIN_HALF <= P < MAX_HALF).
- States (locked = 1 only in LOCK):
  - IDLE:
    - valid -> ACQ, half_per <= P.
    - An invalid edge stays in IDLE.
  - ACQ:
    - valid and |P - half_per| <= TOL -> LOCK.
    - valid otherwise -> stay in ACQ.
    - Either valid case loads half_per <= P.
    - Invalid edge -> IDLE; half_per is unchanged.
  - LOCK:
    - valid and |P - half_per| <= TOL -> stay in LOCK, half_per <= P.
    - valid and outside TOL -> ACQ, half_per <= P.
    - Invalid edge -> IDLE.
  - Timeout: in ACQ or LOCK, cnt == MAX_HALF -> IDLE.
- Output:
  - Every edge cycle, in any state: sgn_lead <= sgn_s and fired <= 0. The output always agrees with the input after a real edge.
  - In LOCK, non-edge cycle with !fired and cnt == half_per - LEAD: sgn_lead <= ~sgn_s, fired <= 1. At most one predicted toggle per half-period.
  - In IDLE/ACQ, sgn_lead simply follows sgn_s, one clock after the edge cycle. Pass-through latency is 3 clocks from a sgn change.
- Edge-case rules:
  - If the real edge arrives before the predicted toggle, the edge-cycle rule applies and no predicted toggle follows in that half-period.
  - A real edge coinciding with the predicted-toggle cycle: the edge rule wins.
  - Lock exit takes effect the same cycle as the causing edge or timeout. No predicted toggle is issued in that cycle.
  - Difference |P - half_per| is computed in CNT_W+1 bits, with no wrap.
- Reset mid-operation returns to IDLE immediately, with outputs at reset values.

Test Plan:
- Reset: assert rst_n=0 with sgn toggling -> sgn_lead=0, locked=0, half_per=0 throughout. After release, the first sgn change appears on sgn_lead exactly 3 clocks later.
- Lock acquire: square wave, half-period 100 clocks.
  - half_per=100 after the 2nd edge.
  - locked=1 after the 3rd edge.
  - From then on, each sgn_lead edge occurs 50 clocks earlier than the pass-through timing: at cnt==50 rather than at the edge.
- Tracking: while locked, change the half-period 100 -> 94 -> locked stays 1, half_per=94, advance remains 50 clocks.
  - Then step to 120 -> locked drops on that edge (ACQ), half_per=120.
  - Relock on the next 120-clock edge.
- Glitch: while locked, insert a 20-clock pulse -> locked=0 on the glitch edge, state IDLE, sgn_lead follows sgn_s with 3-clock latency.
  - Relock after two further valid half-periods.
- Timeout: while locked, hold sgn constant -> cnt saturates at 255, locked=0 at that cycle, sgn_lead equals sgn_s, half_per retains 100.
- Early edge / reset mid-lock:
  - Locked at 100, then one half-period of 40 -> invalid, IDLE, sgn_lead matches sgn_s, no extra toggle.
  - Separately, pulse rst_n low mid-half-period -> all outputs 0 asynchronously.
